nonce_scanner: RTL and testbench

- Initiator side of the miner start/done handshake.
- Latches one block header and sweeps the nonce over a programmed range. For each nonce it drives the double-SHA256 miner, waits for done, and compares the returned hash against the target expanded from the compact `bits` field.
- Stops on the first hash <= target, on range exhaustion, on abort, or on miner timeout.
- Sits between the host register interface and the miner core.

---
 rtl/miner_pkg.sv | 33 +++
 rtl/compact_target_expand.sv | 34 +++
 rtl/nonce_scanner.sv | 182 ++++++++++++++++++
 tb/tb_nonce_scanner.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/miner_pkg.sv
// Shared definitions for the nonce scanner and its target expander.
package miner_pkg;

    localparam int HEADER_BYTES = 80;
    localparam int HASH_W       = 256;
    localparam int NONCE_W      = 32;

    // Compact difficulty encoding: exponent in the top byte, mantissa below.
    localparam int EXP_MSB = 31;
    localparam int MAN_W   = 24;

    // Header bits held by the scanner, i.e. everything except the nonce.
    localparam int HDR_W = (HEADER_BYTES - NONCE_W / 8) * 8;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_EXPAND,
        ST_ISSUE,
        ST_WAIT,
        ST_CHECK,
        ST_GAP,
        ST_FOUND,
        ST_EXHAUSTED,
        ST_ERROR
    } state_t;

    // States in which a new start request may be taken.
    function automatic logic is_ready(state_t s);
        return (s == ST_IDLE) || (s == ST_FOUND) ||
               (s == ST_EXHAUSTED) || (s == ST_ERROR);
    endfunction

endpackage

// File: rtl/compact_target_expand.sv
// Combinational expansion of the compact 'bits' field into a 256-bit target.
module compact_target_expand
    import miner_pkg::*;
(
    input  logic [31:0]       bits,
    output logic [HASH_W-1:0] target
);

    logic [7:0]        exp_f;
    logic [MAN_W-1:0]  man;
    logic [HASH_W-1:0] man_ext;
    logic [10:0]       sh_left;
    logic [10:0]       sh_right;

    assign exp_f    = bits[EXP_MSB -: 8];
    assign man      = bits[MAN_W-1:0];
    assign man_ext  = {{(HASH_W - MAN_W){1'b0}}, man};
    // Byte shifts expressed in bits: 8*(exp-3) and 8*(3-exp).
    assign sh_left  = {exp_f, 3'b000} - 11'd24;
    assign sh_right = 11'd24 - {exp_f, 3'b000};

    // A set sign bit means a negative target, which no hash can meet.
    always_comb begin
        target = '0;
        if (man[MAN_W-1]) begin
            target = '0;
        end else if (exp_f <= 8'd3) begin
            target = man_ext >> sh_right;
        end else begin
            target = man_ext << sh_left;
        end
    end

endmodule

// File: rtl/nonce_scanner.sv
// Sweeps the nonce over a programmed range, driving the miner one hash at a
// time and stopping on the first hash at or below the expanded target.
module nonce_scanner
    import miner_pkg::*;
#(
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic [31:0]         version,
    input  logic [31:0]         timestamp,
    input  logic [31:0]         bits,
    input  logic [HASH_W-1:0]   hash_prev,
    input  logic [HASH_W-1:0]   merkle_root,
    input  logic [NONCE_W-1:0]  nonce_first,
    input  logic [NONCE_W-1:0]  nonce_last,
    output logic                busy,
    output logic                found,
    output logic                exhausted,
    output logic                error,
    output logic [NONCE_W-1:0]  result_nonce,
    output logic [HASH_W-1:0]   result_hash,
    output logic [NONCE_W:0]    hash_count,
    output logic [31:0]         m_version,
    output logic [31:0]         m_timestamp,
    output logic [31:0]         m_bits,
    output logic [NONCE_W-1:0]  m_nonce,
    output logic [HASH_W-1:0]   m_hash_prev,
    output logic [HASH_W-1:0]   m_merkle_root,
    output logic                m_start,
    input  logic                m_done,
    input  logic [HASH_W-1:0]   m_hash
);

    localparam logic [31:0] GAP_LAST = 32'(GAP_CYCLES - 1);
    localparam logic [31:0] TO_LAST  = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);
    localparam logic        TO_EN    = (TIMEOUT != 0);

    state_t            state;
    logic [HDR_W-1:0]  hdr_q;
    logic [NONCE_W-1:0] cur_nonce;
    logic [NONCE_W-1:0] last_nonce;
    logic [HASH_W-1:0] target_w;
    logic [HASH_W-1:0] target_q;
    logic [HASH_W-1:0] hash_q;
    logic [31:0]       gap_cnt;
    logic [31:0]       wait_cnt;
    logic              accept;
    logic              hit;
    logic              at_last;

    // Header layout matches the serialised block header minus the nonce.
    assign m_version     = hdr_q[HDR_W-1   -: 32];
    assign m_hash_prev   = hdr_q[HDR_W-33  -: HASH_W];
    assign m_merkle_root = hdr_q[HDR_W-289 -: HASH_W];
    assign m_timestamp   = hdr_q[63:32];
    assign m_bits        = hdr_q[31:0];

    assign accept  = is_ready(state) && start && !abort;
    assign hit     = (hash_q <= target_q);
    assign at_last = (cur_nonce == last_nonce);

    compact_target_expand u_expand (
        .bits   (m_bits),
        .target (target_w)
    );

    // Working datapath registers; only meaningful while a sweep is active.
    always_ff @(posedge clk) begin
        if (accept) begin
            cur_nonce  <= nonce_first;
            last_nonce <= nonce_last;
        end else if (state == ST_CHECK && !hit && !at_last) begin
            cur_nonce  <= cur_nonce + 32'd1;
        end
        if (state == ST_EXPAND) begin
            target_q <= target_w;
        end
        if (state == ST_WAIT && m_done) begin
            hash_q <= m_hash;
        end
    end

    // Sweep controller with registered handshake, status and result outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            hdr_q        <= '0;
            busy         <= 1'b0;
            found        <= 1'b0;
            exhausted    <= 1'b0;
            error        <= 1'b0;
            result_nonce <= '0;
            result_hash  <= '0;
            hash_count   <= '0;
            m_nonce      <= '0;
            m_start      <= 1'b0;
            gap_cnt      <= '0;
            wait_cnt     <= '0;
        end else if (abort) begin
            state     <= ST_IDLE;
            m_start   <= 1'b0;
            busy      <= 1'b0;
            found     <= 1'b0;
            exhausted <= 1'b0;
            error     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_FOUND, ST_EXHAUSTED, ST_ERROR: begin
                    if (start) begin
                        hdr_q      <= {version, hash_prev, merkle_root, timestamp, bits};
                        hash_count <= '0;
                        busy       <= 1'b1;
                        found      <= 1'b0;
                        exhausted  <= 1'b0;
                        error      <= 1'b0;
                        m_start    <= 1'b0;
                        state      <= ST_EXPAND;
                    end
                end
                ST_EXPAND: begin
                    state <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    m_nonce  <= cur_nonce;
                    m_start  <= 1'b1;
                    wait_cnt <= '0;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A done arriving on the expiry cycle still counts.
                    if (m_done) begin
                        hash_count <= hash_count + 33'd1;
                        state      <= ST_CHECK;
                    end else if (TO_EN && wait_cnt == TO_LAST) begin
                        m_start      <= 1'b0;
                        error        <= 1'b1;
                        busy         <= 1'b0;
                        result_nonce <= cur_nonce;
                        state        <= ST_ERROR;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                ST_CHECK: begin
                    m_start <= 1'b0;
                    if (hit) begin
                        found        <= 1'b1;
                        busy         <= 1'b0;
                        result_nonce <= cur_nonce;
                        result_hash  <= hash_q;
                        state        <= ST_FOUND;
                    end else if (at_last) begin
                        exhausted    <= 1'b1;
                        busy         <= 1'b0;
                        result_nonce <= cur_nonce;
                        result_hash  <= hash_q;
                        state        <= ST_EXHAUSTED;
                    end else begin
                        gap_cnt <= '0;
                        state   <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    // Keeps m_start low long enough for the miner to drop done.
                    if (gap_cnt == GAP_LAST) begin
                        state <= ST_ISSUE;
                    end else begin
                        gap_cnt <= gap_cnt + 32'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nonce_scanner.sv
// Testbench for nonce_scanner with a fixed-latency stub miner.
module tb_nonce_scanner;

    localparam int GAP = 2;
    localparam int TO  = 20;
    localparam int LAT = 10;
    localparam logic [255:0] GENESIS =
        256'h000000000019d6689c085ae165831e934ff763ae46a2a6c172b3f1b60a8ce26f;
    localparam logic [255:0] ONES = {256{1'b1}};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, start, abort;
    logic [31:0] version, timestamp, bits, nonce_first, nonce_last;
    logic [255:0] hash_prev, merkle_root;
    logic busy, found, exhausted, error, m_start, m_done;
    logic [31:0] result_nonce, m_version, m_timestamp, m_bits, m_nonce;
    logic [255:0] result_hash, m_hash_prev, m_merkle_root, m_hash;
    logic [32:0] hash_count;

    nonce_scanner #(.GAP_CYCLES(GAP), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .version(version), .timestamp(timestamp), .bits(bits),
        .hash_prev(hash_prev), .merkle_root(merkle_root),
        .nonce_first(nonce_first), .nonce_last(nonce_last),
        .busy(busy), .found(found), .exhausted(exhausted), .error(error),
        .result_nonce(result_nonce), .result_hash(result_hash), .hash_count(hash_count),
        .m_version(m_version), .m_timestamp(m_timestamp), .m_bits(m_bits), .m_nonce(m_nonce),
        .m_hash_prev(m_hash_prev), .m_merkle_root(m_merkle_root),
        .m_start(m_start), .m_done(m_done), .m_hash(m_hash)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int stub_mode = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Hash returned by the stub for each scenario.
    function automatic logic [255:0] stub_hash(input int mode, input logic [31:0] n);
        case (mode)
            0: return (n == 32'd5) ? 256'h0fff : ONES;
            1: return (n == 32'd1) ? 256'h0fff : ONES;
            2: return (n == 32'h7C2BAC1D) ? GENESIS : ONES;
            3: return 256'd1;
            default: return ONES;
        endcase
    endfunction

    // Stub miner: done LAT cycles after m_start rises, held until m_start drops.
    int st_cnt;
    always @(posedge clk) begin
        if (reset || !m_start) begin
            st_cnt <= 0;
            m_done <= 1'b0;
            if (reset) m_hash <= '0;
        end else if (!m_done && stub_mode != 4) begin
            if (st_cnt == LAT - 1) begin
                m_done <= 1'b1;
                m_hash <= stub_hash(stub_mode, m_nonce);
            end else begin
                st_cnt <= st_cnt + 1;
            end
        end
    end

    // Target as mantissa times 256^(exp-3), computed arithmetically.
    function automatic logic [255:0] model_target(input logic [31:0] b);
        logic [255:0] t;
        int e;
        e = int'(b[31:24]);
        if (b[23]) return '0;
        t = {232'd0, b[23:0]};
        if (e <= 3) begin
            for (int i = e; i < 3; i++) t = t / 256;
        end else begin
            for (int i = 3; i < e; i++) t = t * 256;
        end
        return t;
    endfunction

    // Outcome of a whole sweep derived directly from the range and the stub.
    function automatic void model_run(input logic [31:0] first, input logic [31:0] last,
                                      input logic [31:0] b, input int mode,
                                      output logic f, output logic x, output logic er,
                                      output logic [31:0] rn, output logic [32:0] cnt,
                                      output logic [255:0] rh);
        logic [31:0] n;
        logic [255:0] tgt, h;
        f = 0; x = 0; er = 0; rn = first; cnt = 0; rh = '0;
        if (mode == 4) begin
            er = 1;
            return;
        end
        tgt = model_target(b);
        n = first;
        for (int g = 0; g < 4096; g++) begin
            h = stub_hash(mode, n);
            cnt = cnt + 1;
            if (h <= tgt) begin
                f = 1; rn = n; rh = h;
                return;
            end
            if (n == last) begin
                x = 1; rn = n; rh = h;
                return;
            end
            n = n + 1;
        end
    endfunction

    logic exp_valid = 0, exp_hash_chk = 0;
    logic e_found, e_exh, e_err;
    logic [31:0] e_nonce;
    logic [32:0] e_cnt;
    logic [255:0] e_hash;

    // Whenever a sweep has ended, outputs must match the model and stay put.
    always @(negedge clk) begin
        if (exp_valid && !busy) begin
            check("found", found, e_found);
            check("exhausted", exhausted, e_exh);
            check("error", error, e_err);
            check("result_nonce", result_nonce, e_nonce);
            check("hash_count", hash_count, e_cnt);
            check("term_m_start", m_start, 0);
            if (exp_hash_chk) check("result_hash", result_hash, e_hash);
        end
    end

    // Tracks the shortest low stretch of m_start between hashes.
    int low_run = 0, min_low = 1000, n_rises = 0;
    logic prev_ms = 1'b0;
    always @(negedge clk) begin
        if (m_start) begin
            if (!prev_ms) begin
                n_rises <= n_rises + 1;
                if (low_run > 0 && low_run < min_low) min_low <= low_run;
            end
            low_run <= 0;
        end else if (n_rises > 0) begin
            low_run <= low_run + 1;
        end
        prev_ms <= m_start;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int k = 0;
        while (busy && k < budget) begin
            tick();
            k++;
        end
        check({name, "_terminates"}, busy, 0);
    endtask

    task automatic run(input logic [31:0] first, input logic [31:0] last, input logic [31:0] b,
                       input int mode, input bit poke, input string name);
        exp_valid = 0;
        stub_mode = mode;
        bits = b;
        nonce_first = first;
        nonce_last = last;
        pulse_start();
        check({name, "_busy"}, busy, 1);
        model_run(first, last, b, mode, e_found, e_exh, e_err, e_nonce, e_cnt, e_hash);
        exp_hash_chk = (mode != 4);
        exp_valid = 1;
        if (poke) begin
            repeat (5) tick();
            nonce_first = 32'd100;
            bits = 32'h2000ffff;
            pulse_start();
        end
        wait_idle(3000, name);
        repeat (4) tick();
    endtask

    initial begin
        int k;
        reset = 1; start = 0; abort = 0;
        version = 32'h00000001; timestamp = 32'h495fab29; bits = 0;
        hash_prev = 256'hdeadbeef; merkle_root = 256'h4a5e1e4b;
        nonce_first = 0; nonce_last = 0;
        repeat (3) tick();
        reset = 0;
        tick();

        check("rst_busy", busy, 0);
        check("rst_found", found, 0);
        check("rst_exhausted", exhausted, 0);
        check("rst_error", error, 0);
        check("rst_m_start", m_start, 0);
        check("rst_result_nonce", result_nonce, 0);
        check("rst_result_hash", result_hash, 0);
        check("rst_hash_count", hash_count, 0);
        check("rst_m_version", m_version, 0);
        check("rst_m_hash_prev", m_hash_prev, 0);

        check("tgt_04000010", model_target(32'h04000010), 256'h1000);
        check("tgt_1d00ffff", model_target(32'h1d00ffff),
              256'h00000000ffff0000000000000000000000000000000000000000000000000000);
        check("tgt_03800000", model_target(32'h03800000), 0);
        check("tgt_02123456", model_target(32'h02123456), 256'h1234);

        run(32'd0, 32'd9, 32'h04000010, 0, 1'b1, "r1");
        check("r1_found", found, 1);
        check("r1_nonce", result_nonce, 5);
        check("r1_count", hash_count, 6);
        check("r1_exhausted", exhausted, 0);
        check("r1_m_bits", m_bits, 32'h04000010);

        low_run = 0; min_low = 1000; n_rises = 0;
        run(32'd6, 32'd9, 32'h04000010, 0, 1'b0, "r2");
        check("r2_exhausted", exhausted, 1);
        check("r2_nonce", result_nonce, 9);
        check("r2_count", hash_count, 4);
        check("r2_hash", result_hash, ONES);
        check("r2_starts", n_rises, 4);
        check("r2_gap_ok", (min_low >= GAP), 1);

        run(32'hFFFFFFFE, 32'd2, 32'h04000010, 1, 1'b0, "r3");
        check("r3_found", found, 1);
        check("r3_nonce", result_nonce, 1);
        check("r3_count", hash_count, 4);

        run(32'h7C2BAC1B, 32'h7C2BAC20, 32'h1d00ffff, 2, 1'b0, "r4");
        check("r4_found", found, 1);
        check("r4_nonce", result_nonce, 32'h7C2BAC1D);
        check("r4_count", hash_count, 3);
        check("r4_hash", result_hash, GENESIS);

        run(32'd0, 32'd7, 32'h03800000, 3, 1'b0, "r5");
        check("r5_found", found, 0);
        check("r5_exhausted", exhausted, 1);
        check("r5_count", hash_count, 8);

        // abort together with start: abort wins
        exp_valid = 0;
        start = 1; abort = 1;
        tick();
        start = 0; abort = 0;
        check("abst_busy", busy, 0);
        check("abst_exhausted", exhausted, 0);

        // abort while waiting on the third hash
        stub_mode = 0; bits = 32'h04000010; nonce_first = 0; nonce_last = 9;
        pulse_start();
        k = 0;
        while (!(hash_count == 2 && m_start && !m_done) && k < 500) begin
            tick();
            k++;
        end
        check("ab_reach_wait", (k < 500), 1);
        abort = 1;
        tick();
        abort = 0;
        check("ab_busy", busy, 0);
        check("ab_m_start", m_start, 0);
        check("ab_found", found, 0);
        check("ab_hash_count", hash_count, 2);

        // reset during the inter-nonce gap
        version = 32'h20000000; merkle_root = 256'hfeed;
        pulse_start();
        k = 0;
        while (!(busy && !m_start && hash_count >= 1) && k < 500) begin
            tick();
            k++;
        end
        check("rg_reach_gap", (k < 500), 1);
        check("rg_pre_version", m_version, 32'h20000000);
        reset = 1;
        tick();
        check("rg_busy", busy, 0);
        check("rg_m_start", m_start, 0);
        check("rg_hash_count", hash_count, 0);
        check("rg_result_nonce", result_nonce, 0);
        check("rg_result_hash", result_hash, 0);
        check("rg_m_version", m_version, 0);
        check("rg_m_merkle", m_merkle_root, 0);
        check("rg_m_bits", m_bits, 0);
        check("rg_m_timestamp", m_timestamp, 0);
        reset = 0;
        tick();

        // miner that never finishes
        stub_mode = 4; nonce_first = 32'h55; nonce_last = 32'h60;
        pulse_start();
        k = 0;
        while (!m_start && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("to_m_start", m_start, 1);
        k = 0;
        while (!error && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("to_cycles", k, 20);
        check("to_m_start_low", m_start, 0);
        model_run(32'h55, 32'h60, bits, 4, e_found, e_exh, e_err, e_nonce, e_cnt, e_hash);
        exp_hash_chk = 0;
        exp_valid = 1;
        repeat (4) tick();
        check("to_error", error, 1);
        check("to_nonce", result_nonce, 32'h55);
        exp_valid = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
